// File: rtl/int_ctrl.sv
// Fixed-priority, nesting interrupt controller with EN/PEND/INSERV/TRIG registers.
// Optional edge-triggered sources and the TRIG register are built when INTC_EDGE_EN is defined.
module int_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [29:0]      Addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic             int_ack,
    output logic [N_SRC-1:0] HWInt
);
    localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

    logic [1:0]       sel;
    logic             ack;
    logic             wr_en;
    logic             wr_pend;
    logic             wr_eoi;
    logic             wr_trig;
    logic [N_SRC-1:0] en_q, en_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] inserv_q, inserv_d;
    logic [N_SRC-1:0] hwint_q, hwint_d;
    logic [N_SRC-1:0] inserv_low;
    logic [N_SRC-1:0] elig_mask;
    logic [N_SRC-1:0] cand;
    logic [N_SRC-1:0] trig_rd;
    logic             unused_bits;

    assign sel         = Addr[3:2];
    assign unused_bits = ^{Addr[29:4], Addr[1:0], Din[31:N_SRC]};

    always_comb begin
        ack      = int_ack & (|hwint_q);
        wr_en    = WE & (sel == 2'd0);
        wr_pend  = WE & (sel == 2'd1);
        wr_eoi   = WE & (sel == 2'd2);
        wr_trig  = WE & (sel == 2'd3);

        en_d     = wr_en ? Din[N_SRC-1:0] : en_q;

        // EOI drops the lowest set bit first, then a same-cycle ack adds its bit.
        inserv_d = inserv_q;
        if (wr_eoi) begin
            inserv_d = inserv_q & (inserv_q - ONE);
        end
        if (ack) begin
            inserv_d = inserv_d | hwint_q;
        end

        // Only indices below the highest-priority in-service bit may preempt;
        // with nothing in service the mask wraps to all ones.
        inserv_low = inserv_q & (~inserv_q + ONE);
        elig_mask  = inserv_low - ONE;
        cand       = pend_q & en_q & elig_mask;
        hwint_d    = ack ? '0 : (cand & (~cand + ONE));
    end

`ifdef INTC_EDGE_EN
    logic [N_SRC-1:0] trig_q, trig_d;
    logic [N_SRC-1:0] irq_prev_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] edge_clr;

    always_comb begin
        rise     = irq_in & ~irq_prev_q;
        edge_clr = (wr_pend ? Din[N_SRC-1:0] : '0) | (ack ? hwint_q : '0);
        // A rising edge in the same cycle as a clear keeps the bit set.
        pend_d   = (trig_q & ((pend_q & ~edge_clr) | rise)) | (~trig_q & irq_in);
        trig_d   = wr_trig ? Din[N_SRC-1:0] : trig_q;
        trig_rd  = trig_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_q     <= '0;
            irq_prev_q <= '0;
        end else begin
            trig_q     <= trig_d;
            irq_prev_q <= irq_in;
        end
    end
`else
    logic unused_wr;

    always_comb begin
        pend_d    = irq_in;
        trig_rd   = '0;
        unused_wr = wr_pend | wr_trig;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q     <= '0;
            pend_q   <= '0;
            inserv_q <= '0;
            hwint_q  <= '0;
        end else begin
            en_q     <= en_d;
            pend_q   <= pend_d;
            inserv_q <= inserv_d;
            hwint_q  <= hwint_d;
        end
    end

    always_comb begin
        Dout = '0;
        case (sel)
            2'd0:    Dout[N_SRC-1:0] = en_q;
            2'd1:    Dout[N_SRC-1:0] = pend_q;
            2'd2:    Dout[N_SRC-1:0] = inserv_q;
            default: Dout[N_SRC-1:0] = trig_rd;
        endcase
    end

    assign HWInt = hwint_q;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: expectations queued as stimulus is applied,
// popped and asserted when the DUT output is sampled.
module tb_int_ctrl;
    localparam int N = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_in;
    logic [29:0]  Addr;
    logic         WE;
    logic [31:0]  Din;
    logic [31:0]  Dout;
    logic         int_ack;
    logic [N-1:0] HWInt;

    logic [31:0] exp_q[$];
    int          checks = 0;
    int          fails  = 0;

    int_ctrl #(.N_SRC(N)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .Addr(Addr), .WE(WE),
        .Din(Din), .Dout(Dout), .int_ack(int_ack), .HWInt(HWInt)
    );

    always #5 clk = ~clk;

    // Offset placed on both Addr[3:2] and Addr[1:0] inside the bridge window.
    function automatic logic [29:0] addr_of(input logic [1:0] off);
        logic [29:0] a;
        a      = 30'h00001fc0;
        a[3:2] = off;
        a[1:0] = off;
        return a;
    endfunction

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s: observed %h with empty expected queue", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        Addr = addr_of(off);
        Din  = data;
        WE   = 1'b1;
        step(1);
        WE   = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] off, input logic [31:0] v);
        push(v);
        Addr = addr_of(off);
        #1;
        chk(tag, Dout);
    endtask

    task automatic chk_hw(input string tag, input logic [N-1:0] v);
        push(32'(v));
        chk(tag, 32'(HWInt));
    endtask

    task automatic ack_pulse;
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        irq_in  = '0;
        Addr    = '0;
        WE      = 1'b0;
        Din     = '0;
        int_ack = 1'b0;
        #12 reset = 1'b0;
        #1;

        chk_hw("reset_hw", 6'b0);
        for (int i = 0; i < 4; i++) chk_rd($sformatf("reset_rd%0d", i), 2'(i), 32'h0);

        // Basic level request
        wr(2'd0, 32'h3f);
        chk_rd("en_rd", 2'd0, 32'h3f);
        irq_in = 6'b000010;
        push(32'h0);
        push(32'h2);
        step(1);
        chk("lvl_lat1", 32'(HWInt));
        step(1);
        chk("lvl_lat2", 32'(HWInt));
        ack_pulse();
        chk_hw("ack_clr_hw", 6'b0);
        chk_rd("ack_inserv", 2'd2, 32'h2);
        step(1);
        chk_hw("inserv_blocks_self", 6'b0);
        wr(2'd2, 32'h0);
        chk_rd("eoi_inserv", 2'd2, 32'h0);
        irq_in = '0;
        step(3);
        chk_hw("lvl_drop_hw", 6'b0);
        chk_rd("lvl_drop_pend", 2'd1, 32'h0);

        // Priority and nesting
        irq_in = 6'b000100;
        step(2);
        chk_hw("src2_hw", 6'b000100);
        ack_pulse();
        chk_rd("src2_inserv", 2'd2, 32'h4);
        irq_in = 6'b000101;
        step(2);
        chk_hw("nest_hw", 6'b000001);
        ack_pulse();
        chk_rd("nest_inserv", 2'd2, 32'h5);
        chk_hw("nest_ack_hw", 6'b0);
        irq_in = '0;
        step(1);
        wr(2'd2, 32'h0);
        chk_rd("eoi1_inserv", 2'd2, 32'h4);
        wr(2'd2, 32'h0);
        chk_rd("eoi2_inserv", 2'd2, 32'h0);
        wr(2'd2, 32'h0);
        chk_rd("eoi_empty", 2'd2, 32'h0);
        step(1);
        chk_hw("nest_idle_hw", 6'b0);

        // Masking
        wr(2'd0, 32'h01);
        irq_in = 6'b000100;
        step(3);
        chk_hw("mask_hw", 6'b0);
        chk_rd("mask_pend", 2'd1, 32'h4);
        wr(2'd0, 32'h04);
        chk_hw("unmask_same", 6'b0);
        step(1);
        chk_hw("unmask_hw", 6'b000100);
        wr(2'd0, 32'h0);
        step(1);
        chk_hw("mask_again_hw", 6'b0);

        // Same-cycle ack and EOI
        wr(2'd0, 32'h3f);
        irq_in = 6'b000010;
        step(2);
        ack_pulse();
        irq_in = 6'b000001;
        step(2);
        chk_hw("pre_ackeoi_hw", 6'b000001);
        Addr    = addr_of(2'd2);
        Din     = '0;
        WE      = 1'b1;
        int_ack = 1'b1;
        step(1);
        WE      = 1'b0;
        int_ack = 1'b0;
        chk_rd("ackeoi_inserv", 2'd2, 32'h1);
        chk_hw("ackeoi_hw", 6'b0);

        // Reset between clock edges while a request is live
        wr(2'd2, 32'h0);
        step(1);
        chk_hw("pre_reset_hw", 6'b000001);
        #2 reset = 1'b1;
        #1;
        chk_hw("mid_reset_hw", 6'b0);
        for (int i = 0; i < 4; i++) chk_rd($sformatf("mid_reset_rd%0d", i), 2'(i), 32'h0);
        irq_in = '0;
        step(1);
        reset = 1'b0;
        step(1);

`ifdef INTC_EDGE_EN
        wr(2'd3, 32'h1);
        chk_rd("trig_rd", 2'd3, 32'h1);
        irq_in = 6'b000001;
        step(1);
        irq_in = '0;
        step(2);
        chk_rd("edge_persist", 2'd1, 32'h1);
        wr(2'd1, 32'h1);
        chk_rd("edge_w1c", 2'd1, 32'h0);
        irq_in = 6'b000001;
        wr(2'd1, 32'h1);
        chk_rd("edge_set_wins", 2'd1, 32'h1);
        irq_in = '0;
`else
        wr(2'd3, 32'h3f);
        chk_rd("trig_absent", 2'd3, 32'h0);
        irq_in = 6'b001000;
        step(1);
        wr(2'd1, 32'h8);
        chk_rd("level_w1c_ignored", 2'd1, 32'h8);
        irq_in = '0;
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
